// File: rtl/game_event_ctrl_pkg.sv
// rtl/game_event_ctrl_pkg.sv - shared state encoding and default game constants
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam int SCORE_W_DEF        = 16;
  localparam int SCORE_STAIR_DEF    = 1;
  localparam int SCORE_MONSTER_DEF  = 10;
  localparam int RESPAWN_FRAMES_DEF = 120;
  localparam int DEATH_FRAMES_DEF   = 60;
  localparam int LIVES_DEF          = 3;

endpackage

// File: rtl/game_event_ctrl_if.sv
// rtl/game_event_ctrl_if.sv - detector flags in, game events and status out
interface game_event_if
  import game_pkg::*;
#(
  parameter int SCORE_W = SCORE_W_DEF
);
  logic               start;
  logic               collision;
  logic               dead;
  logic               beat_monster;
  logic               hit;
  logic               fell_out;
  logic               bounce;
  logic               monster_kill;
  logic               monster_appear;
  logic [SCORE_W-1:0] score;
  logic               dying;
  logic               game_over;
  logic [1:0]         lives;

  modport master (
    output start, collision, dead, beat_monster, hit, fell_out,
    input  bounce, monster_kill, monster_appear, score, dying, game_over, lives
  );

  modport slave (
    input  start, collision, dead, beat_monster, hit, fell_out,
    output bounce, monster_kill, monster_appear, score, dying, game_over, lives
  );
endinterface

// File: rtl/game_event_ctrl_frame_tick_sync.sv
// rtl/game_event_ctrl_frame_tick_sync.sv - frame strobe synchronizer and rising-edge pulse
module frame_tick_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk,
  output logic frame_tick
);
  logic sync1, sync2, sync_prev;

  // Two flops against metastability, a third as edge history; the pulse is registered
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync_prev  <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      sync1      <= frame_clk;
      sync2      <= sync1;
      sync_prev  <= sync2;
      frame_tick <= sync2 & ~sync_prev;
    end
  end
endmodule

// File: rtl/game_event_ctrl.sv
// rtl/game_event_ctrl.sv - game FSM turning per-frame flags into events; lives option GAME_LIVES_EN
module game_event_ctrl
  import game_pkg::*;
#(
  parameter int SCORE_W        = SCORE_W_DEF,
  parameter int SCORE_STAIR    = SCORE_STAIR_DEF,
  parameter int SCORE_MONSTER  = SCORE_MONSTER_DEF,
  parameter int RESPAWN_FRAMES = RESPAWN_FRAMES_DEF,
  parameter int DEATH_FRAMES   = DEATH_FRAMES_DEF
`ifdef GAME_LIVES_EN
  ,
  parameter int LIVES          = LIVES_DEF
`endif
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  game_event_if.slave ev
);
  localparam int RESP_W  = $clog2(RESPAWN_FRAMES + 2);
  localparam int DEATH_W = $clog2(DEATH_FRAMES + 1);
  localparam logic [RESP_W-1:0]  RESP_LOAD  = RESP_W'(RESPAWN_FRAMES);
  localparam logic [DEATH_W-1:0] DEATH_LAST = DEATH_W'(DEATH_FRAMES - 1);
  localparam logic [SCORE_W:0]   INC_STAIR  = (SCORE_W + 1)'(SCORE_STAIR);
  localparam logic [SCORE_W:0]   INC_MON    = (SCORE_W + 1)'(SCORE_MONSTER);

  game_state_t        state_q, state_d;
  logic               tick;
  logic               prev_coll, prev_dead, prev_beat, prev_hit;
  logic               ev_coll, ev_dead, ev_beat, ev_hit;
  logic               play_tick, hit_fire, beat_fire, die_now, stair_fire;
  logic               death_done, start_game, relaunch_fire;
  logic               bounce_q, kill_q, appear_q;
  logic [SCORE_W-1:0] score_q, score_next;
  logic [SCORE_W:0]   score_inc, score_sum;
  logic [RESP_W-1:0]  resp_cnt;
  logic [DEATH_W-1:0] death_cnt;

  frame_tick_sync u_tick (
    .Clk        (Clk),
    .Reset      (Reset),
    .frame_clk  (frame_clk),
    .frame_tick (tick)
  );

  // Frame events and the in-frame priority: bullet hit, stomp, death, stair landing
  always_comb begin
    ev_coll    = tick & ev.collision    & ~prev_coll;
    ev_dead    = tick & ev.dead         & ~prev_dead;
    ev_beat    = tick & ev.beat_monster & ~prev_beat;
    ev_hit     = tick & ev.hit          & ~prev_hit;
    play_tick  = tick && (state_q == PLAY);
    hit_fire   = play_tick & ev_hit & appear_q;
    beat_fire  = play_tick & ~hit_fire & ev_beat & appear_q;
    die_now    = play_tick & ((ev_dead & appear_q & ~hit_fire & ~beat_fire) | ev.fell_out);
    stair_fire = play_tick & ev_coll & ~beat_fire & ~die_now;
    death_done = tick && (state_q == DYING) && (death_cnt == DEATH_LAST);
    start_game = ev.start && ((state_q == IDLE) || (state_q == OVER));
  end

  // Saturating score update for whatever scored this frame
  always_comb begin
    score_inc = '0;
    if (hit_fire || beat_fire) score_inc = score_inc + INC_MON;
    if (stair_fire)            score_inc = score_inc + INC_STAIR;
    score_sum  = {1'b0, score_q} + score_inc;
    score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ev.start)   state_d = PLAY;
      PLAY:    if (die_now)    state_d = DYING;
      DYING:   if (death_done) state_d = relaunch_fire ? PLAY : OVER;
      OVER:    if (ev.start)   state_d = PLAY;
      default:                 state_d = IDLE;
    endcase
  end

  // State-decoded status outputs
  always_comb begin
    ev.dying     = (state_q == DYING);
    ev.game_over = (state_q == OVER);
  end

  // Event pulses, flag history, score, monster respawn and death timing
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bounce_q  <= 1'b0;
      kill_q    <= 1'b0;
      appear_q  <= 1'b0;
      score_q   <= '0;
      resp_cnt  <= RESP_LOAD;
      death_cnt <= '0;
      prev_coll <= 1'b0;
      prev_dead <= 1'b0;
      prev_beat <= 1'b0;
      prev_hit  <= 1'b0;
    end else begin
      bounce_q <= beat_fire | stair_fire | relaunch_fire;
      kill_q   <= hit_fire | beat_fire;
      if (tick) begin
        prev_coll <= ev.collision;
        prev_dead <= ev.dead;
        prev_beat <= ev.beat_monster;
        prev_hit  <= ev.hit;
      end
      if (start_game) begin
        score_q  <= '0;
        appear_q <= 1'b0;
        resp_cnt <= RESP_LOAD;
      end else if (state_q == PLAY) begin
        score_q <= score_next;
        if (hit_fire || beat_fire) begin
          appear_q <= 1'b0;
          resp_cnt <= RESP_LOAD;
        end else if (tick && !appear_q) begin
          if (resp_cnt <= RESP_W'(1)) begin
            appear_q <= 1'b1;
            resp_cnt <= '0;
          end else begin
            resp_cnt <= resp_cnt - RESP_W'(1);
          end
        end
      end else if (relaunch_fire) begin
        appear_q <= 1'b0;
        resp_cnt <= RESP_LOAD;
      end
      if (die_now)
        death_cnt <= '0;
      else if (tick && (state_q == DYING) && !death_done)
        death_cnt <= death_cnt + DEATH_W'(1);
    end
  end

`ifdef GAME_LIVES_EN
  logic [1:0] lives_q;
  assign relaunch_fire = death_done && (lives_q > 2'd1);

  // Lives load on a fresh game and drop by one at the end of each death animation
  always_ff @(posedge Clk) begin
    if (Reset)           lives_q <= 2'd0;
    else if (start_game) lives_q <= 2'(LIVES);
    else if (death_done) lives_q <= (lives_q > 2'd1) ? lives_q - 2'd1 : 2'd0;
  end

  assign ev.lives = lives_q;
`else
  assign relaunch_fire = 1'b0;
  assign ev.lives      = 2'd0;
`endif

  assign ev.bounce         = bounce_q;
  assign ev.monster_kill   = kill_q;
  assign ev.monster_appear = appear_q;
  assign ev.score          = score_q;
endmodule

// File: tb/tb_game_event_ctrl.sv
// tb/tb_game_event_ctrl.sv - directed bench for game_event_ctrl, second 4-bit-score instance for saturation
module tb_game_event_ctrl;
  logic Clk, Reset, frame_clk;
  int   n_checks = 0;
  int   n_errors = 0;
  int   bounce_cnt = 0;
  int   kill_cnt = 0;
  int   frames;
  int   b0, k0;

  game_event_if #(.SCORE_W(16)) ev ();
  game_event_if #(.SCORE_W(4))  ev4 ();

  assign ev4.start        = ev.start;
  assign ev4.collision    = ev.collision;
  assign ev4.dead         = ev.dead;
  assign ev4.beat_monster = ev.beat_monster;
  assign ev4.hit          = ev.hit;
  assign ev4.fell_out     = ev.fell_out;

  game_event_ctrl dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .ev        (ev)
  );

  game_event_ctrl #(.SCORE_W(4)) dut4 (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .ev        (ev4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(negedge Clk) begin
    if (ev.bounce)       bounce_cnt++;
    if (ev.monster_kill) kill_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  task automatic frame();
    frame_clk = 1'b1;
    step(4);
    frame_clk = 1'b0;
    step(4);
  endtask

  task automatic pulse_start();
    ev.start = 1'b1;
    step(1);
    ev.start = 1'b0;
    step(1);
  endtask

  task automatic wait_appear(output int n);
    n = 0;
    while (!ev.monster_appear && n < 200) begin
      frame();
      n++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    Reset = 1'b1;
    frame_clk = 1'b0;
    ev.start = 1'b0;
    ev.collision = 1'b0;
    ev.dead = 1'b0;
    ev.beat_monster = 1'b0;
    ev.hit = 1'b0;
    ev.fell_out = 1'b0;
    step(4);
    Reset = 1'b0;
    step(1);

    check_eq("rst_bounce", 32'(ev.bounce), 0);
    check_eq("rst_kill", 32'(ev.monster_kill), 0);
    check_eq("rst_appear", 32'(ev.monster_appear), 0);
    check_eq("rst_score", 32'(ev.score), 0);
    check_eq("rst_dying", 32'(ev.dying), 0);
    check_eq("rst_over", 32'(ev.game_over), 0);
    check_eq("rst_lives", 32'(ev.lives), 0);

    b0 = bounce_cnt;
    ev.collision = 1'b1;
    frame();
    ev.collision = 1'b0;
    frame();
    check_eq("idle_no_bounce", 32'(bounce_cnt - b0), 0);
    check_eq("idle_score", 32'(ev.score), 0);

    pulse_start();
    check_eq("play_over", 32'(ev.game_over), 0);
    check_eq("play_dying", 32'(ev.dying), 0);

    b0 = bounce_cnt;
    ev.collision = 1'b1;
    frame_clk = 1'b1;
    step(3);
    check_eq("bounce_lat3", 32'(ev.bounce), 0);
    step(1);
    check_eq("bounce_lat4", 32'(ev.bounce), 1);
    frame_clk = 1'b0;
    step(1);
    check_eq("bounce_width", 32'(ev.bounce), 0);
    step(3);
    repeat (4) frame();
    ev.collision = 1'b0;
    check_eq("stair_bounces", 32'(bounce_cnt - b0), 1);
    check_eq("stair_score", 32'(ev.score), 1);

    wait_appear(frames);
    check_eq("first_respawn_frames", 32'(frames + 5), 120);
    check_eq("appear_up", 32'(ev.monster_appear), 1);

    b0 = bounce_cnt;
    k0 = kill_cnt;
    ev.beat_monster = 1'b1;
    ev.collision = 1'b1;
    frame();
    ev.beat_monster = 1'b0;
    ev.collision = 1'b0;
    check_eq("stomp_bounce", 32'(bounce_cnt - b0), 1);
    check_eq("stomp_kill", 32'(kill_cnt - k0), 1);
    check_eq("stomp_score", 32'(ev.score), 11);
    check_eq("stomp_score4", 32'(ev4.score), 11);
    check_eq("stomp_appear", 32'(ev.monster_appear), 0);

    wait_appear(frames);
    check_eq("respawn_after_kill", 32'(frames), 120);

    b0 = bounce_cnt;
    k0 = kill_cnt;
    ev.hit = 1'b1;
    ev.dead = 1'b1;
    frame();
    ev.hit = 1'b0;
    ev.dead = 1'b0;
    check_eq("hit_kill", 32'(kill_cnt - k0), 1);
    check_eq("hit_no_bounce", 32'(bounce_cnt - b0), 0);
    check_eq("hit_not_dying", 32'(ev.dying), 0);
    check_eq("hit_score", 32'(ev.score), 21);
    check_eq("hit_score4_sat", 32'(ev4.score), 15);
    check_eq("hit_appear", 32'(ev.monster_appear), 0);

    wait_appear(frames);
    check_eq("respawn_after_hit", 32'(frames), 120);

    b0 = bounce_cnt;
    ev.dead = 1'b1;
    frame();
    ev.dead = 1'b0;
    check_eq("dead_dying", 32'(ev.dying), 1);
    check_eq("dead_not_over", 32'(ev.game_over), 0);
    for (int i = 1; i <= 59; i++) begin
      if (i == 10) ev.collision = 1'b1;
      if (i == 20) ev.collision = 1'b0;
      if (i == 30) pulse_start();
      frame();
    end
    check_eq("dying_59_dying", 32'(ev.dying), 1);
    check_eq("dying_59_over", 32'(ev.game_over), 0);
    check_eq("dying_no_bounce", 32'(bounce_cnt - b0), 0);
    frame();
    check_eq("over_flag", 32'(ev.game_over), 1);
    check_eq("over_dying", 32'(ev.dying), 0);
    check_eq("over_score", 32'(ev.score), 21);

    pulse_start();
    check_eq("restart_over", 32'(ev.game_over), 0);
    check_eq("restart_score", 32'(ev.score), 0);
    check_eq("restart_appear", 32'(ev.monster_appear), 0);

    ev.collision = 1'b1;
    frame();
    ev.collision = 1'b0;
    check_eq("restart_stair", 32'(ev.score), 1);
    ev.fell_out = 1'b1;
    frame();
    ev.fell_out = 1'b0;
    check_eq("fell_dying", 32'(ev.dying), 1);
    frame();

    Reset = 1'b1;
    step(1);
    check_eq("mid_rst_dying", 32'(ev.dying), 0);
    check_eq("mid_rst_over", 32'(ev.game_over), 0);
    check_eq("mid_rst_score", 32'(ev.score), 0);
    check_eq("mid_rst_score4", 32'(ev4.score), 0);
    check_eq("mid_rst_appear", 32'(ev.monster_appear), 0);
    check_eq("mid_rst_bounce", 32'(ev.bounce), 0);
    Reset = 1'b0;
    step(1);

    b0 = bounce_cnt;
    ev.collision = 1'b1;
    frame();
    ev.collision = 1'b0;
    check_eq("post_rst_idle", 32'(bounce_cnt - b0), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/game_event_ctrl.md
Name: game_event_ctrl

Overview:
- Consumer of the collision flags (stair collision, monster dead/beat, bullet hit) and of the doodler fall-out condition.
- Converts level-held per-frame flags into single game events: bounce request, monster kill, score update, death and game-over sequence.
- Drives monster_appear back to the collision/monster logic, closing the loop between detectors and game state.
- Sits between the collision detectors and the doodler/monster/score-display blocks.

Parameters:
- SCORE_W, 16, width of score counter
- SCORE_STAIR, 1, points per new stair landing
- SCORE_MONSTER, 10, points per monster kill (stomp or bullet)
- RESPAWN_FRAMES, 120, frames a monster stays absent before reappearing
- DEATH_FRAMES, 60, frames spent in the death/fall animation
- LIVES, 3, starting lives (used only with GAME_LIVES_EN)

Ports:
- Clk  in  1  system clock; all state on posedge Clk
- Reset  in  1  synchronous, active-high
- frame_clk  in  1  vertical-sync-rate strobe, asynchronous to Clk
- start  in  1  level; start/restart request
- collision  in  1  doodler-stair collision flag
- dead  in  1  doodler touched monster (not from above)
- beat_monster  in  1  doodler stomped monster
- hit  in  1  bullet hit monster
- fell_out  in  1  doodler below bottom of screen
- bounce  out  1  one-Clk pulse: doodler must restart upward jump
- monster_kill  out  1  one-Clk pulse: monster destroyed
- monster_appear  out  1  monster visible/active
- score  out  SCORE_W  current score
- dying  out  1  high during death animation
- game_over  out  1  high in OVER state
- lives  out  2  remaining lives (driven 0 without GAME_LIVES_EN)

Behaviour:
- Reset (sync, high): state IDLE; score 0; bounce, monster_kill, monster_appear, dying, game_over all 0; respawn counter = RESPAWN_FRAMES; death counter 0; edge history 0.
- frame_clk: 2-flop synchronizer, then rising-edge detector → frame_tick, one Clk wide. Latency 3 Clk from frame_clk rise. All input flags are sampled only on frame_tick.
- Event detection: per flag, keep the previous sampled value; an event is a 0→1 transition between consecutive frame_ticks. A flag held high across frames yields exactly one event.
- Outputs bounce and monster_kill are registered and assert on the Clk after frame_tick, for exactly one Clk.
- States:
  - IDLE: all events ignored. start=1 → PLAY; score cleared; respawn counter reloaded.
  - PLAY: events evaluated per frame in the priority order below.
  - DYING: dying=1; all flags ignored; death counter increments each frame_tick; at DEATH_FRAMES-1 → OVER.
  - OVER: game_over=1; start=1 → PLAY with score 0, monster_appear 0, respawn reloaded.
- PLAY priority within one frame (highest first):
  1. hit event with monster_appear=1: monster_kill pulse; monster_appear←0; respawn reload; score += SCORE_MONSTER. A dead event in the same frame is cancelled.
  2. beat_monster event with monster_appear=1: monster_kill pulse, bounce pulse, monster_appear←0, reload, score += SCORE_MONSTER.
  3. dead event (monster_appear=1) or fell_out=1 (level, not edge): → DYING; death counter 0.
  4. collision event: bounce pulse; score += SCORE_STAIR. collision is ignored in any frame where rule 2 fired, so only one bounce is issued.
- Flags gated by monster_appear=0 are ignored.
- Respawn: in PLAY with monster_appear=0, the counter decrements each frame_tick. At 0: monster_appear←1. Counter holds while not in PLAY.
- Score arithmetic: unsigned, saturates at 2^SCORE_W-1; no wrap.
- start while in PLAY or DYING: no effect.
- Reset mid-game: returns to IDLE next Clk regardless of state; pending pulses dropped.

Optional Feature:
- Macro: GAME_LIVES_EN.
- Defined:
  - Lives counter loaded with LIVES on entry to PLAY from IDLE/OVER.
  - DYING end with lives>1: lives-1; → PLAY; score kept; monster_appear←0; respawn reloaded; bounce pulse issued to relaunch the doodler.
  - DYING end with lives=1: lives←0; → OVER.
- Undefined: lives tied to 0; DYING always → OVER.

Decomposition:
- Package game_pkg holds:
  - state enum (IDLE, PLAY, DYING, OVER, 2 bits);
  - default score constants;
  - SCORE_W default.
- Sub-module frame_tick_sync (synchronizer + rising-edge detector, output frame_tick).

Test Plan:
- Reset, start=1, one frame with collision 0→1 held 5 frames → one bounce pulse, score=1.
- PLAY, 120 frames with no monster → monster_appear=1 on the Clk after the 120th frame_tick.
- monster_appear=1; beat_monster and collision rise in the same frame → one bounce, one monster_kill, score +10 (not +11), monster_appear=0.
- monster_appear=1; hit and dead rise in the same frame → monster_kill, state stays PLAY, score +10.
- dead rises → dying=1 for 60 frames, then game_over=1; start → score=0, game_over=0. With GAME_LIVES_EN: lives 3→2, back to PLAY.
- Score preset near 65535, +10 → saturates at 65535. Reset asserted in DYING → IDLE, all outputs 0 next Clk.
